// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port synchronous RAM.
// A requester can lock the RAM across grants for an atomic read-modify-write.
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic                     lock0,
  input  logic                     lock1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t     owner;
  logic       last;
  logic [1:0] vld_p1;
  logic       sel0_p0;
  logic       sel1_p0;

  // Issue stage: pick the winner and drive the RAM pins in the same cycle.
  always_comb begin
    sel0_p0 = 1'b0;
    sel1_p0 = 1'b0;
    if (!reset) begin
      case (owner)
        OWN_P0: sel0_p0 = req0;
        OWN_P1: sel1_p0 = req1;
        default: begin
          if (req0 && req1) begin
            // On a tie the port that did not win last time goes next.
            sel0_p0 = last;
            sel1_p0 = ~last;
          end else begin
            sel0_p0 = req0;
            sel1_p0 = req1;
          end
        end
      endcase
    end
  end

  assign gnt0       = sel0_p0;
  assign gnt1       = sel1_p0;
  assign mem_wEn    = (sel0_p0 & we0) | (sel1_p0 & we1);
  assign mem_addr   = sel1_p0 ? addr1 : addr0;
  assign mem_dataIn = sel1_p0 ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last   <= 1'b1;
      owner  <= OWN_NONE;
      vld_p1 <= 2'b00;
    end else begin
      vld_p1 <= {sel1_p0 & ~we1, sel0_p0 & ~we0};
      if (sel0_p0) begin
        last  <= 1'b0;
        owner <= lock0 ? OWN_P0 : OWN_NONE;
      end else if (sel1_p0) begin
        last  <= 1'b1;
        owner <= lock1 ? OWN_P1 : OWN_NONE;
      end
    end
  end

  // Return stage: RAM read data arrives one cycle after the grant.
  // Gating with reset drops a read response that lands while reset is held.
  assign rvalid0 = vld_p1[0] & ~reset;
  assign rvalid1 = vld_p1[1] & ~reset;
  assign rdata   = mem_dataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed-vector bench for ram_port_arbiter with a behavioural RAM and a
// grant/read-data scoreboard checked by an independent monitor.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_wEn;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn;
  logic [DW-1:0] mem_dataOut;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gexp_t;

  gexp_t         gq[$];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];

  int n_checks = 0;
  int n_pass   = 0;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_wEn(mem_wEn), .mem_addr(mem_addr),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  // Single-port RAM: 1-cycle registered read, dataOut holds on writes.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    else mem_dataOut <= ram[mem_addr];
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void fail_now(string nm);
    n_checks++;
    $display("FAIL %s: got unexpected event expected none at %0t", nm, $time);
  endfunction

  // Monitor: every grant and every read response is matched to the scoreboard.
  always @(negedge clk) begin
    gexp_t e;
    if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
      if (gnt0 && gnt1) fail_now("dual_grant");
      if (gq.size() == 0) fail_now("grant_unexpected");
      else begin
        e = gq.pop_front();
        chk("grant_port", {63'd0, gnt1}, {63'd0, e.port});
        chk("grant_we", {63'd0, mem_wEn}, {63'd0, e.we});
        chk("grant_addr", {52'd0, mem_addr}, {52'd0, e.addr});
        if (e.we) chk("grant_wdata", {32'd0, mem_dataIn}, {32'd0, e.data});
      end
    end
    if (rvalid0 === 1'b1) begin
      if (rq0.size() == 0) fail_now("rvalid0_unexpected");
      else chk("rdata_p0", {32'd0, rdata}, {32'd0, rq0.pop_front()});
    end
    if (rvalid1 === 1'b1) begin
      if (rq1.size() == 0) fail_now("rvalid1_unexpected");
      else chk("rdata_p1", {32'd0, rdata}, {32'd0, rq1.pop_front()});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(logic r, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic drv1(logic r, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  task automatic expg(logic p, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    gexp_t e;
    e.port = p; e.we = w; e.addr = a; e.data = d;
    gq.push_back(e);
  endtask

  task automatic quiet_check(string nm);
    @(negedge clk);
    chk(nm, {59'd0, gnt0, gnt1, mem_wEn, rvalid0, rvalid1}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] pa [4];
    logic [DW-1:0] pd [4];
    pa[0] = 12'h010; pd[0] = 32'hDEADBEEF;
    pa[1] = 12'h100; pd[1] = 32'h11110000;
    pa[2] = 12'h200; pd[2] = 32'h22220000;
    pa[3] = 12'h020; pd[3] = 32'h00000005;

    // Reset with both ports requesting: nothing may be issued.
    reset = 1'b1;
    drv0(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    drv1(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_addr = pa[i]; pl_data = pd[i];
      quiet_check("reset_outputs");
      nxt();
    end
    pl_en = 1'b0;
    reset = 1'b0;
    drv0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();

    // Single read on port 0.
    drv0(1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    expg(1'b0, 1'b0, 12'h010, 32'h0); rq0.push_back(32'hDEADBEEF);
    nxt();
    drv0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();

    // Port 1 write then read-back.
    drv1(1'b1, 1'b1, 1'b0, 12'h0FF, 32'h12345678);
    expg(1'b1, 1'b1, 12'h0FF, 32'h12345678);
    nxt();
    drv1(1'b1, 1'b0, 1'b0, 12'h0FF, 32'h0);
    expg(1'b1, 1'b0, 12'h0FF, 32'h0); rq1.push_back(32'h12345678);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();

    // Contention, no lock: last was port 1, so 0,1,0,1.
    drv0(1'b1, 1'b0, 1'b0, 12'h100, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 12'h200, 32'h0);
    for (int i = 0; i < 2; i++) begin
      expg(1'b0, 1'b0, 12'h100, 32'h0); rq0.push_back(32'h11110000);
      expg(1'b1, 1'b0, 12'h200, 32'h0); rq1.push_back(32'h22220000);
    end
    repeat (4) nxt();
    drv0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();
    nxt();

    // Port 0 write so that port 1 wins the next tie.
    drv0(1'b1, 1'b1, 1'b0, 12'h030, 32'h30303030);
    expg(1'b0, 1'b1, 12'h030, 32'h30303030);
    nxt();

    // Locked read-modify-write on port 1 while port 0 keeps requesting.
    drv0(1'b1, 1'b0, 1'b0, 12'h030, 32'h0);
    drv1(1'b1, 1'b0, 1'b1, 12'h020, 32'h0);
    expg(1'b1, 1'b0, 12'h020, 32'h0); rq1.push_back(32'h00000005);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();
    drv1(1'b1, 1'b1, 1'b0, 12'h020, 32'h00000006);
    expg(1'b1, 1'b1, 12'h020, 32'h00000006);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    expg(1'b0, 1'b0, 12'h030, 32'h0); rq0.push_back(32'h30303030);
    nxt();
    drv0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
    expg(1'b1, 1'b0, 12'h020, 32'h0); rq1.push_back(32'h00000006);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();

    // Locked read on port 0, then reset lands on its return cycle.
    drv0(1'b1, 1'b0, 1'b1, 12'h010, 32'h0);
    expg(1'b0, 1'b0, 12'h010, 32'h0);
    nxt();
    reset = 1'b1;
    drv0(1'b1, 1'b0, 1'b0, 12'h100, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 12'h200, 32'h0);
    quiet_check("reset_mid_lock");
    nxt();
    reset = 1'b0;
    expg(1'b0, 1'b0, 12'h100, 32'h0); rq0.push_back(32'h11110000);
    expg(1'b1, 1'b0, 12'h200, 32'h0); rq1.push_back(32'h22220000);
    nxt();
    drv0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();
    drv1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    nxt();
    nxt();

    // Idle.
    for (int i = 0; i < 10; i++) begin
      quiet_check("idle_outputs");
      nxt();
    end

    chk("grant_queue_drained", 64'(gq.size()), 64'd0);
    chk("rdata0_queue_drained", 64'(rq0.size()), 64'd0);
    chk("rdata1_queue_drained", 64'(rq1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM instance between two requesters: port 0, the processor data-memory side, and port 1, the sonar sample writer/reader.
- Round-robin arbitration, one access per cycle, with an optional lock so a requester can hold the RAM for an atomic read-modify-write.
- Sits between both requesters and the RAM's clk/wEn/addr/dataIn/dataOut pins; the RAM has a 1-cycle registered read, and dataOut does not update on write cycles.

Parameters:
- DATA_WIDTH, 32, word width of the RAM and both requester ports.
- ADDRESS_WIDTH, 12, address width of the RAM and both requester ports.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- req0, req1  in  1 each  access request; held high until granted.
- we0, we1  in  1 each  1 = write, 0 = read; valid while reqN is high.
- lock0, lock1  in  1 each  keep ownership after this grant; valid while reqN is high.
- addr0, addr1  in  ADDRESS_WIDTH each  access address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- gnt0, gnt1  out  1 each  combinational; high in the cycle the access is issued to the RAM.
- rvalid0, rvalid1  out  1 each  registered; high for one cycle, the cycle after a granted read.
- rdata  out  DATA_WIDTH  read data, shared by both ports; equals mem_dataOut and is qualified by rvalidN.
- mem_wEn  out  1  to RAM wEn.
- mem_addr  out  ADDRESS_WIDTH  to RAM addr.
- mem_dataIn  out  DATA_WIDTH  to RAM dataIn.
- mem_dataOut  in  DATA_WIDTH  from RAM dataOut.

Behaviour:
- State:
  - last: 1 bit, last granted port; reset value 1, so port 0 wins the first tie.
  - owner: 2 bits, encoded NONE / P0 / P1; reset value NONE.
  - rv: 2 bits, rvalid pipeline; reset value 00.
- Reset: while reset is high, gnt0 = gnt1 = 0, mem_wEn = 0, rvalid0 = rvalid1 = 0.
  - mem_addr and mem_dataIn are don't-care during reset but must not produce X on mem_wEn.
- Winner selection when owner = NONE:
  - Exactly one reqN high: that port wins.
  - Both high: the port != last wins.
  - Neither high: no grant, mem_wEn = 0.
- Winner selection when owner = Pk:
  - Only port k can be granted; the other port's req is ignored and that port waits.
  - If reqk is low, no access is issued that cycle and ownership persists.
- Issue in the grant cycle (combinational from the winner):
  - gntN = 1.
  - mem_wEn = weN, mem_addr = addrN, mem_dataIn = wdataN.
- Updates at the next posedge:
  - last <= winner.
  - rv[N] <= gntN & ~weN.
  - owner <= Pk if lockk was high at the granted access, else NONE.
- Read latency: the request is accepted in cycle T, and rvalidN = 1 with rdata valid in cycle T+1.
- Back-to-back: a new grant may issue in cycle T+1 while the T read returns. Sustained throughput is 1 access per cycle.
- Fairness: with both ports requesting continuously and no locks, grants alternate 0,1,0,1.
- Lock release: a granted access with lockk = 0 frees the RAM. Arbitration resumes the next cycle using the normal last rule.
- Reset mid-lock:
  - owner returns to NONE and last to 1.
  - An rvalid due in the cycle after reset asserts is suppressed.
- Requester hold rule:
  - A requester must hold req/we/addr/wdata/lock stable until it sees gnt.
  - A requester may drop req before gnt; nothing is issued for it.
- Inputs sampled in a grant cycle are used only in that cycle; no internal request buffering.

Test Plan:
- Single read: preload RAM[0x010] = 0xDEADBEEF; req0 = 1, we0 = 0, addr0 = 0x010 -> gnt0 in cycle T; rvalid0 = 1 with rdata = 0xDEADBEEF in T+1; rvalid1 stays 0.
- Write then read:
  - req1 writes 0x12345678 to 0x0FF -> gnt1 with mem_wEn = 1.
  - Next cycle req1 reads 0x0FF -> rdata = 0x12345678 one cycle after the grant.
- Contention: req0 and req1 both held for 4 cycles after reset, no lock -> grant order 0,1,0,1; each read's rvalid appears on the correct port one cycle later.
- Lock RMW:
  - Port 1 reads 0x020 with lock1 = 1 while req0 is held high.
  - Port 1 then writes 0x020 with lock1 = 0.
  - Required: gnt0 stays 0 through both port 1 accesses, then is granted the next cycle.
- Reset during lock: port 0 locks via a locked read; assert reset for 1 cycle -> the rvalid is suppressed, gnt outputs and mem_wEn are 0 during reset; afterwards a simultaneous req0/req1 grants port 0 first.
- Idle: no requests for 10 cycles -> mem_wEn = 0, gnt = 0, rvalid = 0 throughout.
